pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-client arbiter that shares the single 256-bit physical memory port between the instruction cache and the data cache of the pipelined core. Each cache presents its own miss/write-back request in the same read/write/resp protocol it would use toward memory directly. The arbiter grants one client at a time with round-robin priority, latches that client's command, runs one memory transaction, buffers the returned line and hands a one-cycle response back to the owner. It sits between the two cache datapaths and the memory model or bus adapter.

## Interface
- ADDR_WIDTH, 32, physical address width.
- LINE_WIDTH, 256, cache line width in bits.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line-fill request.
- i_pmem_address  in  ADDR_WIDTH  I-cache request address.
- i_pmem_rdata  out  LINE_WIDTH  line returned to the I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to the I-cache.
- d_pmem_read  in  1  D-cache line-fill request.
- d_pmem_write  in  1  D-cache write-back request.
- d_pmem_address  in  ADDR_WIDTH  D-cache request address.
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back line.
- d_pmem_rdata  out  LINE_WIDTH  line returned to the D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_address  out  ADDR_WIDTH  memory address, line aligned.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.

## Operation
- **States:**
  - IDLE: no grant.
  - BUSY: a command is outstanding to memory.
  - RESP: the response pulse is being returned to the owner.
- **Registers:**
  - state, owner (0 = I, 1 = D) and last_grant.
  - cmd_read, cmd_write, cmd_addr and cmd_wdata.
  - line_buf (LINE_WIDTH).
- **IDLE, arbitration:**
  - The I request is i_pmem_read. The D request is d_pmem_read | d_pmem_write.
  - If only one client requests, grant it.
  - If both request, grant the client that is not last_grant.
- **On grant:**
  - Set owner and update last_grant.
  - Latch cmd_addr = {address[ADDR_WIDTH-1:5], 5'b0}.
  - Latch cmd_read and cmd_write, plus cmd_wdata (D only).
  - Go to BUSY.
- **D read and write both high** is an illegal request. It is latched as a write only: cmd_write = 1, cmd_read = 0.
- **BUSY:**
  - pmem_read = cmd_read and pmem_write = cmd_write.
  - pmem_address = cmd_addr and pmem_wdata = cmd_wdata.
  - Client inputs are ignored, so a client changing them mid-transaction has no effect.
  - On pmem_resp: capture line_buf <= pmem_rdata (on reads; writes leave line_buf unchanged), then go to RESP.
- **RESP:**
  - Assert the owner's *_pmem_resp for exactly one cycle, then go to IDLE.
  - No memory command is driven.
- **Read data:** i_pmem_rdata and d_pmem_rdata both continuously drive line_buf. Only the owner's resp qualifies the data.
- **Stray responses:** pmem_resp in IDLE or RESP is ignored, with no state or buffer change.
- **Idle outputs:** pmem_read, pmem_write, both resps = 0. pmem_address and pmem_wdata hold the last cmd values.

## Timing
- **Reset (rst_n low, any state, immediate):**
  - state = IDLE and last_grant = I (so D wins the first conflict).
  - owner = 0, and all cmd_* and line_buf = 0.
  - All outputs = 0.
  - An in-flight memory transaction is abandoned.
- **Sequence:**
  - Request seen high in IDLE at edge N gives a grant, with pmem_read/pmem_write high from cycle N+1.
  - The command stays asserted until the edge at which pmem_resp = 1 is sampled (edge K).
  - Commands drop in cycle K+1, where the owner's resp = 1 and line_buf already holds the data.
  - Cycle K+2 is IDLE, and arbitration happens at edge K+2.
- **Latency:** minimum client-visible latency, request to resp, is 2 cycles plus memory latency. The minimum gap between back-to-back memory commands is 2 cycles.
- **Client rule:** a client holds its request until it sees resp and must drop or change it the cycle after resp. A request still high in IDLE is treated as a new request.
- **Fairness:** under continuous requests from both clients, grants alternate I/D, so neither client waits more than one transaction.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n = 0 mid-BUSY with pmem_read = 1.
  - Required response: pmem_read = 0 and both resps = 0 immediately. After release with no requests, state stays IDLE.
- **Single I fill:**
  - Stimulus: i_pmem_read = 1 with address 0x0000_1234; memory returns pmem_resp 3 cycles after the command, with pmem_rdata = 0xA5…A5.
  - Required response: pmem_address = 0x0000_1220. i_pmem_resp pulses once, 1 cycle after pmem_resp, with i_pmem_rdata = 0xA5…A5. d_pmem_resp stays 0.
- **Simultaneous first conflict:**
  - Stimulus: both clients request in the same cycle right after reset.
  - Required response: D is served first and I next. Under continuous requests the grant order is D, I, D, I.
- **D write-back:**
  - Stimulus: d_pmem_write = 1 with wdata pattern 0x1122…; change d_pmem_wdata during BUSY.
  - Required response: pmem_wdata holds the original value throughout, pmem_read = 0, and line_buf is unchanged.
- **Illegal D request:**
  - Stimulus: d_pmem_read = d_pmem_write = 1.
  - Required response: only pmem_write = 1.
- **Stray response:**
  - Stimulus: pmem_resp = 1 pulsed while IDLE, with pmem_rdata = 0xFF…FF.
  - Required response: no client resp, and line_buf is unchanged.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-wide physical memory port between the
// I-cache and D-cache; one transaction at a time, response returned to the owner.
module pmem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state;
   logic                  owner;
   logic                  last_grant;
   logic                  cmd_read;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LINE_WIDTH-1:0] cmd_wdata;
   logic [LINE_WIDTH-1:0] line_buf;

   logic i_req;
   logic d_req;
   logic grant_d;
   logic unused_low_addr;

   assign i_req   = i_pmem_read;
   assign d_req   = d_pmem_read | d_pmem_write;
   // On a tie the client that did not win last time is served.
   assign grant_d = d_req & (~i_req | ~last_grant);

   // Line-offset bits are discarded when the command is latched.
   assign unused_low_addr = ^{i_pmem_address[4:0], d_pmem_address[4:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         cmd_read   <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         line_buf   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  owner      <= grant_d;
                  last_grant <= grant_d;
                  if (grant_d) begin
                     cmd_addr  <= {d_pmem_address[ADDR_WIDTH-1:5], 5'b0};
                     cmd_read  <= d_pmem_read & ~d_pmem_write;
                     cmd_write <= d_pmem_write;
                     cmd_wdata <= d_pmem_wdata;
                  end else begin
                     cmd_addr  <= {i_pmem_address[ADDR_WIDTH-1:5], 5'b0};
                     cmd_read  <= 1'b1;
                     cmd_write <= 1'b0;
                  end
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (pmem_resp) begin
                  if (cmd_read) begin
                     line_buf <= pmem_rdata;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign pmem_read    = (state == BUSY) & cmd_read;
   assign pmem_write   = (state == BUSY) & cmd_write;
   assign pmem_address = cmd_addr;
   assign pmem_wdata   = cmd_wdata;

   assign i_pmem_resp  = (state == RESP) & ~owner;
   assign d_pmem_resp  = (state == RESP) & owner;
   assign i_pmem_rdata = line_buf;
   assign d_pmem_rdata = line_buf;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   localparam int P_IDLE  = 0;
   localparam int P_GRANT = 1;
   localparam int P_BUSY  = 2;
   localparam int P_RESP  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_pmem_read;
   logic [AW-1:0] i_pmem_address;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int errors = 0;
   int checks = 0;
   logic [LW-1:0] tbuf;

   always #5 clk = ~clk;

   pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      i_pmem_read    = 1'b0;
      i_pmem_address = '0;
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_address = '0;
      d_pmem_wdata   = '0;
      pmem_resp      = 1'b0;
      pmem_rdata     = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== '0 ||
          pmem_wdata !== '0 || i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h, all required 0",
                  pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address);
      end
      rst_n = 1'b1;
      tick();
      i_pmem_read    = 1'b1;
      i_pmem_address = 32'h0000_4044;
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_4040) begin
         errors++;
         $display("FAIL reset_pre_busy: rd=%b addr=%h, required 1 00004040", pmem_read, pmem_address);
      end
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== '0) begin
         errors++;
         $display("FAIL reset_mid_busy: rd=%b wr=%b iresp=%b dresp=%b addr=%h, required all 0",
                  pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address);
      end
      i_pmem_read = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: cycle %0d rd=%b wr=%b iresp=%b dresp=%b, required 0",
                     c, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
         end
      end
   endtask

   task automatic test_single_i;
      logic [LW-1:0] a5;
      a5 = {8{32'hA5A5_A5A5}};
      i_pmem_read    = 1'b1;
      i_pmem_address = 32'h0000_1234;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1220 ||
             i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL single_i_cmd: cycle %0d rd=%b wr=%b addr=%h iresp=%b dresp=%b, required 1 0 00001220 0 0",
                     c, pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp);
         end
      end
      pmem_resp  = 1'b1;
      pmem_rdata = a5;
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      checks++;
      if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0 || pmem_read !== 1'b0 || i_pmem_rdata !== a5) begin
         errors++;
         $display("FAIL single_i_resp: iresp=%b dresp=%b rd=%b rdata=%h, required 1 0 0 %h",
                  i_pmem_resp, d_pmem_resp, pmem_read, i_pmem_rdata, a5);
      end
      i_pmem_read = 1'b0;
      tick();
      checks++;
      if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin
         errors++;
         $display("FAIL single_i_pulse: iresp=%b dresp=%b rd=%b, required 0 0 0",
                  i_pmem_resp, d_pmem_resp, pmem_read);
      end
      tbuf = a5;
   endtask

   task automatic test_conflict;
      bit            exp_d[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [AW-1:0] ai, ad, exp_addr;
      logic [LW-1:0] rd;
      int            n;
      do_reset();
      ai = 32'h0000_0107;
      ad = 32'h0000_201F;
      i_pmem_read = 1'b1;
      d_pmem_read = 1'b1;
      for (int t = 0; t < 4; t++) begin
         i_pmem_address = ai;
         d_pmem_address = ad;
         n = 0;
         tick();
         while (!(pmem_read | pmem_write) && n < 6) begin
            tick();
            n++;
         end
         checks++;
         if (!(pmem_read | pmem_write)) begin
            errors++;
            $display("FAIL conflict_timeout: txn %0d no command within 6 cycles", t);
         end
         exp_addr = (exp_d[t] ? ad : ai) & 32'hFFFF_FFE0;
         checks++;
         if (pmem_address !== exp_addr) begin
            errors++;
            $display("FAIL conflict_addr: txn %0d addr=%h, required %h", t, pmem_address, exp_addr);
         end
         rd = {8{32'h0101_0101 * (t + 1)}};
         pmem_resp  = 1'b1;
         pmem_rdata = rd;
         tick();
         pmem_resp = 1'b0;
         checks++;
         if ({i_pmem_resp, d_pmem_resp} !== (exp_d[t] ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL conflict_order: txn %0d iresp=%b dresp=%b, required owner %s",
                     t, i_pmem_resp, d_pmem_resp, exp_d[t] ? "D" : "I");
         end
         checks++;
         if ((exp_d[t] ? d_pmem_rdata : i_pmem_rdata) !== rd) begin
            errors++;
            $display("FAIL conflict_rdata: txn %0d rdata=%h, required %h",
                     t, exp_d[t] ? d_pmem_rdata : i_pmem_rdata, rd);
         end
         tbuf = rd;
         ai = ai + 32'h40;
         ad = ad + 32'h40;
      end
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_write_back;
      logic [LW-1:0] wd;
      wd = {2{128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00}};
      d_pmem_write   = 1'b1;
      d_pmem_address = 32'h0000_3018;
      d_pmem_wdata   = wd;
      tick();
      d_pmem_wdata   = ~wd;
      d_pmem_address = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== wd || pmem_address !== 32'h0000_3000) begin
            errors++;
            $display("FAIL wb_cmd: cycle %0d wr=%b rd=%b addr=%h wdata=%h, required 1 0 00003000 %h",
                     c, pmem_write, pmem_read, pmem_address, pmem_wdata, wd);
         end
         if (c < 2) tick();
      end
      pmem_resp  = 1'b1;
      pmem_rdata = '1;
      tick();
      pmem_resp = 1'b0;
      checks++;
      if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0 || pmem_write !== 1'b0 || d_pmem_rdata !== tbuf) begin
         errors++;
         $display("FAIL wb_resp: dresp=%b iresp=%b wr=%b rdata=%h, required 1 0 0 %h",
                  d_pmem_resp, i_pmem_resp, pmem_write, d_pmem_rdata, tbuf);
      end
      d_pmem_write = 1'b0;
      tick();
      checks++;
      if (d_pmem_resp !== 1'b0 || pmem_wdata !== wd) begin
         errors++;
         $display("FAIL wb_idle_hold: dresp=%b wdata=%h, required 0 %h", d_pmem_resp, pmem_wdata, wd);
      end
   endtask

   task automatic test_illegal;
      d_pmem_read    = 1'b1;
      d_pmem_write   = 1'b1;
      d_pmem_address = 32'h0000_5003;
      d_pmem_wdata   = rand_line();
      tick();
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_5000) begin
         errors++;
         $display("FAIL illegal_cmd: wr=%b rd=%b addr=%h, required 1 0 00005000",
                  pmem_write, pmem_read, pmem_address);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = rand_line();
      tick();
      pmem_resp = 1'b0;
      checks++;
      if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== tbuf) begin
         errors++;
         $display("FAIL illegal_resp: dresp=%b rdata=%h, required 1 %h", d_pmem_resp, d_pmem_rdata, tbuf);
      end
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      tick();
   endtask

   task automatic test_stray;
      pmem_resp  = 1'b1;
      pmem_rdata = '1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
            errors++;
            $display("FAIL stray_outputs: cycle %0d rd=%b wr=%b iresp=%b dresp=%b, required 0",
                     c, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
         end
      end
      pmem_resp = 1'b0;
      tick();
      checks++;
      if (i_pmem_rdata !== tbuf || d_pmem_rdata !== tbuf || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
         errors++;
         $display("FAIL stray_buffer: irdata=%h drdata=%h, required %h", i_pmem_rdata, d_pmem_rdata, tbuf);
      end
   endtask

   task automatic test_random;
      int            phase = P_IDLE;
      int            lat = 0;
      int            n_txn = 0;
      int            k;
      bit            ireq = 1'b0, dreq = 1'b0;
      bit            m_last_d = 1'b0, m_own_d = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
      logic [AW-1:0] m_addr = '0;
      logic [LW-1:0] m_wdata = '0, m_buf = '0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         checks++;
         if (pmem_address !== m_addr || pmem_wdata !== m_wdata || i_pmem_rdata !== m_buf || d_pmem_rdata !== m_buf) begin
            errors++;
            $display("FAIL rand_hold: cycle %0d addr=%h required %h, buf match=%b wdata match=%b",
                     cyc, pmem_address, m_addr, i_pmem_rdata === m_buf && d_pmem_rdata === m_buf, pmem_wdata === m_wdata);
         end
         i_pmem_address = $urandom;
         d_pmem_address = $urandom;
         d_pmem_wdata   = rand_line();
         case (phase)
            P_IDLE: begin
               checks++;
               if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
                  errors++;
                  $display("FAIL rand_idle: cycle %0d rd=%b wr=%b iresp=%b dresp=%b, required 0",
                           cyc, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
               end
               if (!ireq && $urandom_range(0, 2) == 0) begin
                  ireq = 1'b1;
                  i_pmem_read = 1'b1;
               end
               if (!dreq && $urandom_range(0, 2) == 0) begin
                  dreq = 1'b1;
                  k = $urandom_range(0, 4);
                  d_pmem_read  = (k < 2) || (k == 4);
                  d_pmem_write = (k >= 2);
               end
               pmem_resp  = ($urandom_range(0, 5) == 0);
               pmem_rdata = rand_line();
               if (ireq || dreq) begin
                  if (ireq && dreq) m_own_d = !m_last_d;
                  else              m_own_d = dreq;
                  m_last_d = m_own_d;
                  if (m_own_d) begin
                     m_addr  = d_pmem_address & 32'hFFFF_FFE0;
                     m_wr    = d_pmem_write;
                     m_rd    = d_pmem_read && !d_pmem_write;
                     m_wdata = d_pmem_wdata;
                  end else begin
                     m_addr = i_pmem_address & 32'hFFFF_FFE0;
                     m_rd   = 1'b1;
                     m_wr   = 1'b0;
                  end
                  phase = P_GRANT;
               end
            end
            P_GRANT, P_BUSY: begin
               checks++;
               if (pmem_read !== m_rd || pmem_write !== m_wr || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_cmd: cycle %0d rd=%b wr=%b iresp=%b dresp=%b, required %b %b 0 0",
                           cyc, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, m_rd, m_wr);
               end
               if (phase == P_GRANT) lat = $urandom_range(0, 3);
               pmem_rdata = rand_line();
               if (lat == 0) begin
                  pmem_resp = 1'b1;
                  if (m_rd) m_buf = pmem_rdata;
                  phase = P_RESP;
               end else begin
                  lat--;
                  pmem_resp = 1'b0;
                  phase = P_BUSY;
               end
            end
            default: begin
               checks++;
               if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_pmem_resp !== !m_own_d || d_pmem_resp !== m_own_d) begin
                  errors++;
                  $display("FAIL rand_resp: cycle %0d rd=%b wr=%b iresp=%b dresp=%b, required owner %s",
                           cyc, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, m_own_d ? "D" : "I");
               end
               n_txn++;
               pmem_resp  = ($urandom_range(0, 3) == 0);
               pmem_rdata = rand_line();
               if (m_own_d) begin
                  dreq = 1'b0;
                  d_pmem_read  = 1'b0;
                  d_pmem_write = 1'b0;
               end else begin
                  ireq = 1'b0;
                  i_pmem_read = 1'b0;
               end
               phase = P_IDLE;
            end
         endcase
         tick();
      end
      checks++;
      if (n_txn < 40) begin
         errors++;
         $display("FAIL rand_progress: %0d transactions completed, required at least 40", n_txn);
      end
      do_reset();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      tbuf  = '0;
      test_reset();
      test_single_i();
      test_conflict();
      test_write_back();
      test_illegal();
      test_stray();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
